// File: rtl/stopwatch_bcd.sv
// MM:SS stopwatch in BCD with run/pause/clear keys. Keys are synchronised and
// falling-edge detected here; the count advances on each divider tick while running.
module stopwatch_bcd #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MINUTES = 59
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       tick_in,
    input  logic       key_run_n,
    input  logic       key_clr_n,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap_pulse
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    localparam logic [6:0] MAX_MIN = 7'(MAX_MINUTES);

    logic [SYNC_STAGES-1:0] run_sync_q, clr_sync_q;
    logic                   run_prev_q, clr_prev_q;
    logic                   run_press, clr_press;

    state_e     state_q, state_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic       running_q;
    logic       wrap_q, wrap_d;
    logic       count_en;
    logic [6:0] min_bin;

    // NOTE: synchroniser and edge register reset to 1 (key released), so coming
    // out of reset with a key already held down still yields a single press.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            run_sync_q <= '1;
            clr_sync_q <= '1;
            run_prev_q <= 1'b1;
            clr_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every stage sampling the
            // pre-edge value, which is what makes this a shift chain.
            run_sync_q <= {run_sync_q[SYNC_STAGES-2:0], key_run_n};
            clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], key_clr_n};
            run_prev_q <= run_sync_q[SYNC_STAGES-1];
            clr_prev_q <= clr_sync_q[SYNC_STAGES-1];
        end
    end

    assign run_press = run_prev_q & ~run_sync_q[SYNC_STAGES-1];
    assign clr_press = clr_prev_q & ~clr_sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (clr_press) begin
            state_d = S_IDLE;
        end else if (run_press) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign count_en = tick_in && (state_q == S_RUN) && !clr_press;
    assign min_bin  = 7'(min_tens_q) * 7'd10 + 7'(min_ones_q);

    // Ripple BCD increment; the wrap branch is reached only from MAX:59.
    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        if (clr_press) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else if (count_en) begin
            if (sec_ones_q != 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q != 4'd5) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_bin >= MAX_MIN) begin
                        min_ones_d = 4'd0;
                        min_tens_d = 4'd0;
                        wrap_d     = 1'b1;
                    end else if (min_ones_q != 4'd9) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        min_tens_d = min_tens_q + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            running_q  <= (state_d == S_RUN);
            wrap_q     <= wrap_d;
        end
    end

    assign sec_ones   = sec_ones_q;
    assign sec_tens   = sec_tens_q;
    assign min_ones   = min_ones_q;
    assign min_tens   = min_tens_q;
    assign running    = running_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: two instances (MAX_MINUTES 1 and 59) share stimulus and
// are compared every cycle against a seconds-count model, plus literal spot checks.
module tb_stopwatch_bcd;

    localparam int S = 2;

    logic       clk_in = 1'b0;
    logic       rst_n_in, tick_in, key_run_n, key_clr_n;
    logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
    logic       a_run, a_wrap, b_run, b_wrap;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    always #5 clk_in = ~clk_in;

    stopwatch_bcd #(.SYNC_STAGES(S), .MAX_MINUTES(1)) dut_a (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .tick_in(tick_in),
        .key_run_n(key_run_n), .key_clr_n(key_clr_n),
        .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
        .running(a_run), .wrap_pulse(a_wrap)
    );

    stopwatch_bcd #(.SYNC_STAGES(S), .MAX_MINUTES(59)) dut_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .tick_in(tick_in),
        .key_run_n(key_run_n), .key_clr_n(key_clr_n),
        .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
        .running(b_run), .wrap_pulse(b_wrap)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Model: elapsed seconds as one integer; a press is a high-to-low step in the
    // key as sampled S and S+1 edges earlier.
    logic [S:0] h_run, h_clr;
    int         m_state;   // 0 idle, 1 run, 2 pause
    int         m_secs_a, m_secs_b;
    bit         m_wrap_a, m_wrap_b;
    bit         p_run, p_clr, cnt;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            h_run = '1; h_clr = '1;
            m_state = 0; m_secs_a = 0; m_secs_b = 0;
            m_wrap_a = 1'b0; m_wrap_b = 1'b0;
        end else begin
            p_run = h_run[S] & ~h_run[S-1];
            p_clr = h_clr[S] & ~h_clr[S-1];
            cnt   = tick_in && (m_state == 1) && !p_clr;
            m_wrap_a = 1'b0;
            m_wrap_b = 1'b0;
            if (p_clr) begin
                m_secs_a = 0;
                m_secs_b = 0;
            end else if (cnt) begin
                if (m_secs_a == 1 * 60 + 59) begin m_secs_a = 0; m_wrap_a = 1'b1; end
                else m_secs_a++;
                if (m_secs_b == 59 * 60 + 59) begin m_secs_b = 0; m_wrap_b = 1'b1; end
                else m_secs_b++;
            end
            if (p_clr) m_state = 0;
            else if (p_run) m_state = (m_state == 1) ? 2 : 1;
            h_run = {h_run[S-1:0], key_run_n};
            h_clr = {h_clr[S-1:0], key_clr_n};
        end
    end

    always @(negedge clk_in) begin
        if (chk_on) begin
            check("cyc_a_digits", {a_mt, a_mo, a_st, a_so}, bcd_of(m_secs_a / 60, m_secs_a % 60));
            check("cyc_a_running", a_run, m_state == 1);
            check("cyc_a_wrap", a_wrap, m_wrap_a);
            check("cyc_b_digits", {b_mt, b_mo, b_st, b_so}, bcd_of(m_secs_b / 60, m_secs_b % 60));
            check("cyc_b_running", b_run, m_state == 1);
            check("cyc_b_wrap", b_wrap, m_wrap_b);
        end
    end

    task automatic do_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in) tick_in = 1'b1;
            @(negedge clk_in) tick_in = 1'b0;
            repeat (gap) @(negedge clk_in);
        end
    endtask

    task automatic press_run();
        @(negedge clk_in) key_run_n = 1'b0;
        repeat (4) @(negedge clk_in);
        key_run_n = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic press_clr();
        @(negedge clk_in) key_clr_n = 1'b0;
        repeat (4) @(negedge clk_in);
        key_clr_n = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic expect_a(input string name, input int mm, input int ss);
        check(name, {a_mt, a_mo, a_st, a_so}, bcd_of(mm, ss));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_in = 1'b0; tick_in = 1'b0; key_run_n = 1'b1; key_clr_n = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        chk_on   = 1'b1;
        check("reset_digits", {a_mt, a_mo, a_st, a_so}, 16'h0000);
        check("reset_running", a_run, 1'b0);
        check("reset_wrap", a_wrap, 1'b0);

        // Start: running rises at edge 2 after first low sample; held key = one press.
        @(negedge clk_in) key_run_n = 1'b0;
        @(posedge clk_in); #1 check("run_edge0", a_run, 1'b0);
        @(posedge clk_in); #1 check("run_edge1", a_run, 1'b0);
        @(posedge clk_in); #1 check("run_edge2", a_run, 1'b1);
        repeat (8) @(negedge clk_in);
        key_run_n = 1'b1;
        repeat (4) @(negedge clk_in);
        check("single_press", a_run, 1'b1);
        do_ticks(12, 3);
        expect_a("start_0012", 0, 12);

        // Carry chain.
        press_clr();
        check("clr_running", a_run, 1'b0);
        press_run();
        for (int i = 1; i <= 61; i++) begin
            do_ticks(1, 3);
            if (i == 59) expect_a("carry_0059", 0, 59);
            if (i == 60) expect_a("carry_0100", 1, 0);
            if (i == 61) expect_a("carry_0101", 1, 1);
        end

        // Wrap at MAX_MINUTES=1 for instance a.
        press_clr();
        press_run();
        do_ticks(119, 3);
        expect_a("pre_wrap_0159", 1, 59);
        do_ticks(1, 0);
        expect_a("wrap_0000", 0, 0);
        check("wrap_pulse_hi", a_wrap, 1'b1);
        check("wrap_running", a_run, 1'b1);
        check("wrap_b_digits", {b_mt, b_mo, b_st, b_so}, 16'h0200);
        @(negedge clk_in);
        check("wrap_pulse_lo", a_wrap, 1'b0);

        // Pause and resume.
        press_clr();
        press_run();
        do_ticks(5, 3);
        press_run();
        do_ticks(7, 3);
        expect_a("paused_0005", 0, 5);
        check("paused_running", a_run, 1'b0);
        press_run();
        do_ticks(3, 3);
        expect_a("resumed_0008", 0, 8);

        // Clear + run press + tick in one cycle while RUN at 00:30.
        do_ticks(22, 3);
        expect_a("at_0030", 0, 30);
        @(negedge clk_in) begin key_run_n = 1'b0; key_clr_n = 1'b0; end
        @(negedge clk_in);
        @(negedge clk_in) tick_in = 1'b1;
        @(negedge clk_in) tick_in = 1'b0;
        expect_a("clr_tick_0000", 0, 0);
        check("clr_tick_running", a_run, 1'b0);
        check("clr_tick_wrap", a_wrap, 1'b0);
        key_run_n = 1'b1; key_clr_n = 1'b1;
        repeat (4) @(negedge clk_in);

        // Run press from IDLE with a coinciding tick: tick not counted.
        @(negedge clk_in) key_run_n = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in) tick_in = 1'b1;
        @(negedge clk_in) tick_in = 1'b0;
        expect_a("idle_tick_0000", 0, 0);
        check("idle_tick_running", a_run, 1'b1);
        key_run_n = 1'b1;
        repeat (4) @(negedge clk_in);

        // Async reset mid-count at 00:45.
        do_ticks(45, 3);
        expect_a("at_0045", 0, 45);
        @(posedge clk_in);
        #3 rst_n_in = 1'b0;
        #1;
        check("async_digits_a", {a_mt, a_mo, a_st, a_so}, 16'h0000);
        check("async_digits_b", {b_mt, b_mo, b_st, b_so}, 16'h0000);
        check("async_running", a_run, 1'b0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        do_ticks(20, 3);
        expect_a("post_reset_idle", 0, 0);
        check("post_reset_running", a_run, 1'b0);

        // Full-range wrap for instance b at 59:59.
        press_run();
        do_ticks(3599, 1);
        check("b_5959", {b_mt, b_mo, b_st, b_so}, 16'h5959);
        do_ticks(1, 0);
        check("b_wrap_digits", {b_mt, b_mo, b_st, b_so}, 16'h0000);
        check("b_wrap_hi", b_wrap, 1'b1);
        @(negedge clk_in);
        check("b_wrap_lo", b_wrap, 1'b0);
        check("b_wrap_running", b_run, 1'b1);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
